// File: rtl/led_blink_code.sv
// led_blink_code: shows a 4-bit status code on one LED as a repeating blink pattern.
// 0 = off, 15 = solid on, 1..14 = that many blinks followed by a long gap.
// A new code is taken only in IDLE or on the last cycle of GAP, so frames are never cut short.
module led_blink_code #(
    parameter int unsigned TICK_DIV       = 50000,
    parameter int unsigned ON_TICKS       = 250,
    parameter int unsigned OFF_TICKS      = 250,
    parameter int unsigned GAP_TICKS      = 1000,
    parameter logic        LED_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] code,
    output logic       led,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned BLK_W = 4;

    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_TICKS - 1);
    localparam logic [CNT_W-1:0] OFF_LAST   = CNT_W'(OFF_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   presc_q, presc_d;
    logic [CNT_W-1:0]   phase_q, phase_d;
    logic [BLK_W-1:0]   blink_q, blink_d;
    logic               led_q, led_d;
    logic               busy_q, busy_d;
    logic               frame_done_q, frame_done_d;

    logic               tick;
    logic               code_valid;
    logic               clear;
    logic               led_on;

    // Next-state, counter and output computation; outputs are derived from the next state
    // so that they register on the same edge as the state itself.
    always_comb begin
        state_d      = state_q;
        blink_d      = blink_q;
        clear        = 1'b0;
        tick         = (presc_q == PRESC_LAST);
        code_valid   = (code != 4'h0) && (code != 4'hF);
        presc_d      = tick ? '0 : presc_q + CNT_W'(1);
        phase_d      = tick ? phase_q + CNT_W'(1) : phase_q;

        case (state_q)
            S_IDLE: begin
                clear = 1'b1;
                if (code_valid) begin
                    state_d = S_ON;
                    blink_d = code;
                end
            end
            S_ON: begin
                if (tick && (phase_q == ON_LAST)) begin
                    clear   = 1'b1;
                    blink_d = blink_q - BLK_W'(1);
                    state_d = (blink_q > BLK_W'(1)) ? S_OFF : S_GAP;
                end
            end
            S_OFF: begin
                if (tick && (phase_q == OFF_LAST)) begin
                    clear   = 1'b1;
                    state_d = S_ON;
                end
            end
            S_GAP: begin
                if (tick && (phase_q == GAP_LAST)) begin
                    clear = 1'b1;
                    if (code_valid) begin
                        state_d = S_ON;
                        blink_d = code;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                clear   = 1'b1;
                state_d = S_IDLE;
            end
        endcase

        if (clear) begin
            presc_d = '0;
            phase_d = '0;
        end

        led_on       = (state_d == S_ON) || ((state_d == S_IDLE) && (code == 4'hF));
        led_d        = led_on ^ LED_ACTIVE_LOW;
        busy_d       = (state_d != S_IDLE);
        // High for the cycle that will be the final cycle of GAP.
        frame_done_d = (state_d == S_GAP) && (presc_d == PRESC_LAST) && (phase_d == GAP_LAST);
    end

    // State, counters and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            presc_q      <= '0;
            phase_q      <= '0;
            blink_q      <= '0;
            led_q        <= LED_ACTIVE_LOW;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            phase_q      <= phase_d;
            blink_q      <= blink_d;
            led_q        <= led_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign led        = led_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule
